// File: rtl/pc_sequencer.sv
// Program-counter sequencer: relative jumps, conditional branches, HALT/resume,
// sticky FAULT. Define PC_SEQ_STACK_EN to include the CALL/RET return stack.
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              OFF_W    = 4,
    parameter int              STACK_D  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step,
    input  logic [2:0]                   op,
    input  logic [OFF_W-1:0]             off,
    input  logic                         zr,
    input  logic                         go,
    output logic [PC_W-1:0]              pc,
    output logic                         taken,
    output logic                         halted,
    output logic                         fault,
    output logic [1:0]                   fault_code,
    output logic [$clog2(STACK_D+1)-1:0] sp
);

    localparam int SP_W = $clog2(STACK_D + 1);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JMPF = 3'd1;
    localparam logic [2:0] OP_JMPB = 3'd2;
    localparam logic [2:0] OP_JIZR = 3'd3;
    localparam logic [2:0] OP_JNZR = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;
    localparam logic [1:0] FC_ILL   = 2'b11;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic [1:0]      fcode_q, fcode_d;
    logic [PC_W-1:0] eff;
    logic [PC_W-1:0] pc_inc;

    assign eff    = PC_W'(off) << 1;
    assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_SEQ_STACK_EN
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [PC_W-1:0]  stack_q [STACK_D];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             push, pop;
    logic [IDX_W-1:0] top_idx;
    logic [PC_W-1:0]  top;

    assign top_idx = IDX_W'(sp_q - SP_W'(1));
    assign top     = (sp_q == '0) ? '0 : stack_q[top_idx];

    // Each entry is written only when the push lands on its slot; reset wipes all.
    for (genvar gi = 0; gi < STACK_D; gi++) begin : g_stack
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stack_q[gi] <= '0;
            end else if (push && sp_q == SP_W'(gi)) begin
                stack_q[gi] <= pc_inc;
            end
        end
    end

    always_comb begin
        sp_d = sp_q;
        if (push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp = sp_q;
`else
    assign sp = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        fcode_d = fcode_q;
`ifdef PC_SEQ_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (state_q)
            S_RUN: begin
                if (step) begin
                    case (op)
                        OP_SEQ:  pc_d = pc_inc;
                        OP_JMPF: begin
                            pc_d    = pc_q + eff;
                            taken_d = 1'b1;
                        end
                        OP_JMPB: begin
                            pc_d    = pc_q - eff;
                            taken_d = 1'b1;
                        end
                        OP_JIZR: begin
                            pc_d    = zr ? pc_q + eff : pc_inc;
                            taken_d = zr;
                        end
                        OP_JNZR: begin
                            pc_d    = zr ? pc_inc : pc_q + eff;
                            taken_d = ~zr;
                        end
`ifdef PC_SEQ_STACK_EN
                        OP_CALL: begin
                            if (sp_q == SP_W'(STACK_D)) begin
                                state_d = S_FAULT;
                                fcode_d = FC_OVER;
                            end else begin
                                push    = 1'b1;
                                pc_d    = pc_q + eff;
                                taken_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                state_d = S_FAULT;
                                fcode_d = FC_UNDER;
                            end else begin
                                pop     = 1'b1;
                                pc_d    = top;
                                taken_d = 1'b1;
                            end
                        end
`else
                        OP_CALL, OP_RET: begin
                            state_d = S_FAULT;
                            fcode_d = FC_ILL;
                        end
`endif
                        OP_HALT: state_d = S_HALTED;
                        default: pc_d = pc_q;
                    endcase
                end
            end
            S_HALTED: begin
                if (go) begin
                    pc_d    = pc_inc;
                    state_d = S_RUN;
                end
            end
            default: begin
                // FAULT is sticky until reset.
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            fcode_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            fcode_q <= fcode_d;
        end
    end

    assign pc         = pc_q;
    assign taken      = taken_q;
    assign halted     = (state_q == S_HALTED);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fcode_q;

endmodule
